fetch_controller: RTL and testbench
===================================

# fetch_controller

Instruction-fetch sequencer that owns the program counter driving the combinational instruction ROM. It registers each fetched word into an instruction register (IR) and hands it to decode over a valid/ready handshake. It also handles branch/jump redirects, HALT instructions and out-of-range PC faults. It sits between the instruction ROM and the decode stage of the 16-bit core.

## Interface
Parameters:
- W, 16, instruction and PC width
- DEPTH, 16, number of valid ROM words; a PC value >= DEPTH is out of range
- RESET_PC, 0, PC loaded at reset and on restart

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin fetching from RESET_PC; sampled in IDLE and HALTED
- pc  out  W  current fetch address to the ROM; driven directly from the PC register
- instruction  in  W  ROM word at pc, combinational and valid in the same cycle
- redirect_valid  in  1  single-cycle branch/jump request
- redirect_target  in  W  new PC, used when redirect_valid=1
- ir  out  W  registered instruction to decode
- ir_pc  out  W  address that ir was fetched from
- ir_valid  out  1  ir holds an instruction not yet consumed
- ir_ready  in  1  decode accepts ir this cycle
- busy  out  1  high in FETCH
- halted  out  1  high in HALTED
- fault  out  1  high in FAULT

## Operation
- States: IDLE, FETCH, HALTED, FAULT.
- Reset values (asynchronous): state=IDLE, pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, busy=0, halted=0, fault=0.
- A transfer occurs when ir_valid && ir_ready.
- The IR can load when it is free: !ir_valid || ir_ready.

IDLE:
- ir_valid=0 and pc holds.
- start=1 moves to FETCH. redirect_valid is ignored.

FETCH, priority order per cycle:
1. redirect_valid=1: pc<=redirect_target and ir_valid<=0 (flush). No load this cycle. If ir_ready is also 1 in the same cycle, the transfer still completes before the flush.
2. pc >= DEPTH: go to FAULT with no load and ir_valid<=0.
3. IR can load: ir<=instruction, ir_pc<=pc, ir_valid<=1.
   - If instruction[15:12]==4'hF (HALT): pc holds and state goes to HALTED.
   - Otherwise pc<=pc+1. The increment is modulo 2^W; the range check on the next cycle catches pc reaching DEPTH.
4. IR cannot load (stall): ir, ir_pc, ir_valid and pc all hold.

HALTED:
- No fetch occurs. The HALT word stays in the IR until consumed; ir_valid clears on transfer.
- redirect_valid is ignored.
- start=1: pc<=RESET_PC, ir_valid<=0 (pending word dropped), state goes to FETCH.

FAULT:
- Sticky. ir_valid=0 and pc holds the offending value.
- All inputs are ignored. Only rst_n exits FAULT.

General:
- Reset asserted mid-operation clears everything immediately, including a pending IR word.
- start while in FETCH is ignored.

## Timing
- pc changes only on clock edges. instruction is sampled at the same edge that pc advances.
- Start latency: start sampled at edge k, state is FETCH after k. ir_valid=1 with the word at RESET_PC after edge k+1.
- Throughput: one instruction per cycle while ir_ready is held at 1.
- Redirect penalty: redirect at edge k means ir_valid=0 after k, and the target word is valid after k+1. That is one bubble.
- The output stays stable while ir_valid=1 && !ir_ready.
- All outputs are registered or derived from state. There is no combinational path from any input to ir, ir_valid or pc.

## Test plan
- Straight-line fetch: ROM[0..3]=16'h1001,16'h1002,16'h1003,16'hF000, ir_ready=1, pulse start. Required response:
  - ir/ir_pc sequence (1001,0),(1002,1),(1003,2),(F000,3) on consecutive cycles.
  - Then halted=1 and pc stays 3.
- Backpressure: during the same program, hold ir_ready=0 for 3 cycles while ir=16'h1002. Required response: ir, ir_pc=1, ir_valid=1 and pc=2 stay constant. On release the sequence resumes with no word lost or duplicated.
- Redirect: at ir_pc=1, assert redirect_valid with redirect_target=8 (ROM[8]=16'h2222) and ir_ready=1. Required response:
  - 16'h1002 is consumed.
  - The next cycle has ir_valid=0.
  - The following cycle has ir=16'h2222 and ir_pc=8.
- Out-of-range fault: DEPTH=16, ROM[15]=16'h1000, redirect to 15. Required response:
  - 16'h1000 is fetched and pc becomes 16.
  - The next cycle sets fault=1 and ir_valid=0.
  - fault stays set despite start or redirect, until rst_n.
- Restart from HALTED: after halt, pulse start. Required response: pc=RESET_PC and ir=ROM[0] two cycles later. Also, a redirect_valid pulse in HALTED leaves pc unchanged.
- Async reset mid-stream: drop rst_n between clock edges while ir_valid=1. Required response: ir_valid=0, pc=0 and state IDLE immediately; fetching resumes only after start.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC driving a combinational ROM, registers each
// fetched word into the IR and offers it to decode over a valid/ready handshake.
// Handles redirects, HALT words and out-of-range PC faults.
module fetch_controller #(
    parameter int unsigned    W        = 16,
    parameter int unsigned    DEPTH    = 16,
    parameter logic [W-1:0]   RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    output logic [W-1:0] pc_o,
    input  logic [W-1:0] instruction_i,
    input  logic         redirect_valid_i,
    input  logic [W-1:0] redirect_target_i,
    output logic [W-1:0] ir_o,
    output logic [W-1:0] ir_pc_o,
    output logic         ir_valid_o,
    input  logic         ir_ready_i,
    output logic         busy_o,
    output logic         halted_o,
    output logic         fault_o
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHalted,
        StFault
    } state_e;

    // One extra bit so DEPTH == 2**W still compares correctly.
    localparam logic [W:0] DepthExt = (W+1)'(DEPTH);
    localparam logic [3:0] HaltOp   = 4'hF;

    state_e       state_q, state_d;
    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] ir_q, ir_d;
    logic [W-1:0] ir_pc_q, ir_pc_d;
    logic         ir_valid_q, ir_valid_d;

    logic transfer;
    logic ir_free;
    logic pc_out_of_range;
    logic is_halt;

    assign transfer        = ir_valid_q && ir_ready_i;
    assign ir_free         = !ir_valid_q || ir_ready_i;
    assign pc_out_of_range = {1'b0, pc_q} >= DepthExt;
    assign is_halt         = instruction_i[W-1 -: 4] == HaltOp;

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    // Next-state and datapath update; everything holds unless a state says otherwise.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;

        unique case (state_q)
            StIdle: begin
                ir_valid_d = 1'b0;
                if (start_i) begin
                    state_d = StFetch;
                end
            end

            StFetch: begin
                if (redirect_valid_i) begin
                    // Flush; a transfer in this same cycle has already happened.
                    pc_d       = redirect_target_i;
                    ir_valid_d = 1'b0;
                end else if (pc_out_of_range) begin
                    state_d    = StFault;
                    ir_valid_d = 1'b0;
                end else if (ir_free) begin
                    ir_d       = instruction_i;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    if (is_halt) begin
                        state_d = StHalted;
                    end else begin
                        // Wraps modulo 2**W; next cycle's range check catches pc == DEPTH.
                        pc_d = pc_q + W'(1);
                    end
                end
            end

            StHalted: begin
                if (transfer) begin
                    ir_valid_d = 1'b0;
                end
                if (start_i) begin
                    // Restart drops any HALT word still pending.
                    pc_d       = RESET_PC;
                    ir_valid_d = 1'b0;
                    state_d    = StFetch;
                end
            end

            StFault: begin
                ir_valid_d = 1'b0;
            end

            default: begin
                state_d    = StIdle;
                ir_valid_d = 1'b0;
            end
        endcase
    end

    // Outputs come straight from registers or decoded state.
    always_comb begin
        pc_o       = pc_q;
        ir_o       = ir_q;
        ir_pc_o    = ir_pc_q;
        ir_valid_o = ir_valid_q;
        busy_o     = state_q == StFetch;
        halted_o   = state_q == StHalted;
        fault_o    = state_q == StFault;
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboarded bench for fetch_controller: stimulus pushes expected (ir, ir_pc) pairs,
// a negedge monitor pops and compares on every handshake transfer.
module tb_fetch_controller;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] pc;
    logic [15:0] instruction;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        busy;
    logic        halted;
    logic        fault;

    int tests;
    int fails;

    logic [15:0] rom [0:31];
    logic [31:0] exp_q [$];

    fetch_controller #(
        .W        (16),
        .DEPTH    (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start_i           (start),
        .pc_o              (pc),
        .instruction_i     (instruction),
        .redirect_valid_i  (redirect_valid),
        .redirect_target_i (redirect_target),
        .ir_o              (ir),
        .ir_pc_o           (ir_pc),
        .ir_valid_o        (ir_valid),
        .ir_ready_i        (ir_ready),
        .busy_o            (busy),
        .halted_o          (halted),
        .fault_o           (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ROM model.
    assign instruction = (pc < 16'd32) ? rom[pc[4:0]] : 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] word, input logic [15:0] addr);
        exp_q.push_back({word, addr});
    endtask

    // Monitor: every handshake transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && ir_valid && ir_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL xfer_unexpected: got ir=%h ir_pc=%h, expected none", ir, ir_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if ({ir, ir_pc} !== e) begin
                    fails++;
                    $display("FAIL xfer: got ir=%h ir_pc=%h, expected ir=%h ir_pc=%h",
                             ir, ir_pc, e[31:16], e[15:0]);
                end
            end
        end
    end

    initial begin
        bit done;
        tests = 0;
        fails = 0;
        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
        rom[0]  = 16'h1001;
        rom[1]  = 16'h1002;
        rom[2]  = 16'h1003;
        rom[3]  = 16'hF000;
        rom[8]  = 16'h2222;
        rom[9]  = 16'hF000;
        rom[15] = 16'h1000;
        rom[16] = 16'h1234;

        start = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 16'h0000;
        ir_ready = 1'b0;
        rst_n = 1'b0;
        #3;
        check("reset_pc", 32'(pc), 32'h0);
        check("reset_ir", {ir, ir_pc}, 32'h0);
        check("reset_flags", {28'h0, ir_valid, busy, halted, fault}, 32'h0);
        #10 rst_n = 1'b1;
        step();

        // Straight-line fetch with a 3-cycle stall on 1002.
        ir_ready = 1'b1;
        push(16'h1001, 16'd0);
        push(16'h1002, 16'd1);
        push(16'h1003, 16'd2);
        push(16'hF000, 16'd3);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", {30'h0, busy, ir_valid}, 32'h2);
        step();
        check("sl_w0", {ir, ir_pc}, {16'h1001, 16'd0});
        check("sl_w0_valid", 32'(ir_valid), 32'h1);
        step();
        check("sl_w1", {ir, ir_pc}, {16'h1002, 16'd1});
        check("sl_w1_pc", 32'(pc), 32'd2);
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_ir", {ir, ir_pc}, {16'h1002, 16'd1});
            check("stall_valid_pc", {15'h0, ir_valid, pc}, {15'h0, 1'b1, 16'd2});
        end
        ir_ready = 1'b1;
        step();
        check("sl_w2", {ir, ir_pc}, {16'h1003, 16'd2});
        step();
        check("sl_w3", {ir, ir_pc}, {16'hF000, 16'd3});
        check("sl_halted", {30'h0, halted, busy}, 32'h2);
        check("sl_halt_pc", 32'(pc), 32'd3);
        step();
        check("halt_drained", {15'h0, ir_valid, pc}, {15'h0, 1'b0, 16'd3});
        check("halt_q_empty", 32'(exp_q.size()), 32'd0);

        // Redirect is ignored in HALTED.
        redirect_valid = 1'b1;
        redirect_target = 16'd8;
        step();
        redirect_valid = 1'b0;
        check("halt_redirect_pc", 32'(pc), 32'd3);
        check("halt_redirect_halted", 32'(halted), 32'h1);

        // Restart, then redirect to 8 while 1002 is being consumed.
        push(16'h1001, 16'd0);
        push(16'h1002, 16'd1);
        push(16'h2222, 16'd8);
        push(16'hF000, 16'd9);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_pc", 32'(pc), 32'd0);
        check("restart_state", {29'h0, busy, halted, ir_valid}, 32'h4);
        step();
        check("restart_ir", {ir, ir_pc}, {16'h1001, 16'd0});
        step();
        check("rd_pre", {ir, ir_pc}, {16'h1002, 16'd1});
        redirect_valid = 1'b1;
        redirect_target = 16'd8;
        step();
        redirect_valid = 1'b0;
        check("rd_bubble", {15'h0, ir_valid, pc}, {15'h0, 1'b0, 16'd8});
        step();
        check("rd_target", {ir, ir_pc}, {16'h2222, 16'd8});
        check("rd_target_valid", 32'(ir_valid), 32'h1);
        step();
        check("rd_halt", {ir, ir_pc}, {16'hF000, 16'd9});
        step();
        check("rd_q_empty", 32'(exp_q.size()), 32'd0);

        // Out-of-range fault after fetching the last valid word.
        push(16'h1000, 16'd15);
        start = 1'b1;
        step();
        start = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = 16'd15;
        step();
        redirect_valid = 1'b0;
        check("flt_pc15", {15'h0, ir_valid, pc}, {15'h0, 1'b0, 16'd15});
        step();
        check("flt_last", {ir, ir_pc}, {16'h1000, 16'd15});
        check("flt_pc16", 32'(pc), 32'd16);
        step();
        check("flt_set", {29'h0, fault, ir_valid, busy}, 32'h4);
        start = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 16'd0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("flt_sticky", {15'h0, fault, pc}, {15'h0, 1'b1, 16'd16});
        end
        start = 1'b0;
        redirect_valid = 1'b0;
        check("flt_q_empty", 32'(exp_q.size()), 32'd0);

        // Async reset mid-stream with a pending IR word.
        #2 rst_n = 1'b0;
        #1;
        check("rst_clears_fault", 32'(fault), 32'h0);
        #2 rst_n = 1'b1;
        ir_ready = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("pend_ir", {15'h0, ir_valid, ir}, {15'h0, 1'b1, 16'h1001});
        #3 rst_n = 1'b0;
        #1;
        check("arst_immediate", {13'h0, ir_valid, busy, halted, pc}, 32'h0);
        check("arst_ir", {ir, ir_pc}, 32'h0);
        #2 rst_n = 1'b1;
        step();
        step();
        check("arst_idle", {14'h0, ir_valid, busy, pc}, 32'h0);

        push(16'h1001, 16'd0);
        push(16'h1002, 16'd1);
        push(16'h1003, 16'd2);
        push(16'hF000, 16'd3);
        ir_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            if (halted && !ir_valid) done = 1'b1;
        end
        check("resume_halt_reached", 32'(done), 32'h1);
        check("resume_q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
